// File: rtl/ps2_arrow_tracker.sv
// PS/2 byte-stream parser that tracks held state of the four arrow keys.
// It also reports press/release pulses and the last complete scancode.
module ps2_arrow_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 16'd50000,
    parameter bit          REPEAT_FILTER  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        left,
    output logic        down,
    output logic        right,
    output logic        up,
    output logic [3:0]  key_press,
    output logic [3:0]  key_release,
    output logic [15:0] scancode,
    output logic        scancode_valid,
    output logic        is_break
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [3:0]      held;
    logic            done;
    logic            code_ext;
    logic            code_brk;
    logic [3:0]      arrow;

    assign left  = held[0];
    assign down  = held[1];
    assign right = held[2];
    assign up    = held[3];

    // Prefix parser and timeout; a byte arriving in the timeout cycle is
    // processed in the current state because the rx_valid branch comes first.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done       = 1'b0;
        code_ext   = 1'b0;
        code_brk   = 1'b0;
        if (rx_valid) begin
            cnt_next = '0;
            unique case (state)
                IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_next = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_next = BRK;
                    end else begin
                        done = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (rx_data != 8'hE0) begin
                        done       = 1'b1;
                        code_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    done       = 1'b1;
                    code_brk   = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    done       = 1'b1;
                    code_ext   = 1'b1;
                    code_brk   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state == IDLE) begin
            cnt_next = '0;
        end else begin
            if (cnt != CNT_SAT) begin
                cnt_next = cnt + CW'(1);
            end
            if (TO_EN && (cnt_next == TMAX)) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    // Only extended codes map onto arrows; keypad codes share the low byte.
    always_comb begin
        arrow = 4'b0000;
        if (code_ext) begin
            unique case (rx_data)
                8'h6B:   arrow = 4'b0001;
                8'h72:   arrow = 4'b0010;
                8'h74:   arrow = 4'b0100;
                8'h75:   arrow = 4'b1000;
                default: arrow = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            held           <= 4'b0000;
            key_press      <= 4'b0000;
            key_release    <= 4'b0000;
            scancode       <= 16'h0000;
            scancode_valid <= 1'b0;
            is_break       <= 1'b0;
        end else if (flush) begin
            state          <= IDLE;
            cnt            <= '0;
            held           <= 4'b0000;
            key_press      <= 4'b0000;
            key_release    <= 4'b0000;
            scancode       <= 16'h0000;
            scancode_valid <= 1'b0;
            is_break       <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            key_press      <= 4'b0000;
            key_release    <= 4'b0000;
            scancode_valid <= done;
            if (done) begin
                scancode <= {(code_ext ? 8'hE0 : 8'h00), rx_data};
                is_break <= code_brk;
                if (code_brk) begin
                    held        <= held & ~arrow;
                    key_release <= arrow & (REPEAT_FILTER ? held : 4'hF);
                end else begin
                    held      <= held | arrow;
                    key_press <= arrow & (REPEAT_FILTER ? ~held : 4'hF);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_arrow_tracker.sv
// Table-driven bench: two trackers (repeat filter on/off) fed the same bytes.
module tb_ps2_arrow_tracker;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        left_a, down_a, right_a, up_a;
    logic [3:0]  press_a, release_a;
    logic [15:0] sc_a;
    logic        sv_a, br_a;

    logic        left_b, down_b, right_b, up_b;
    logic [3:0]  press_b, release_b;
    logic [15:0] sc_b;
    logic        sv_b, br_b;

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0]  data;
        int          gap;
        bit          fl;
        logic [3:0]  held;
        logic [3:0]  pa;
        logic [3:0]  pb;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] sc;
        bit          sv;
        bit          br;
    } vec_t;

    vec_t tbl[$];

    ps2_arrow_tracker #(.TIMEOUT_CYCLES(8), .REPEAT_FILTER(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rx_data(rx_data), .rx_valid(rx_valid),
        .left(left_a), .down(down_a), .right(right_a), .up(up_a),
        .key_press(press_a), .key_release(release_a),
        .scancode(sc_a), .scancode_valid(sv_a), .is_break(br_a)
    );

    ps2_arrow_tracker #(.TIMEOUT_CYCLES(8), .REPEAT_FILTER(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .rx_data(rx_data), .rx_valid(rx_valid),
        .left(left_b), .down(down_b), .right(right_b), .up(up_b),
        .key_press(press_b), .key_release(release_b),
        .scancode(sc_b), .scancode_valid(sv_b), .is_break(br_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] data, input int gap, input bit fl,
                                input logic [3:0] held, input logic [3:0] pa,
                                input logic [3:0] pb, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [15:0] sc,
                                input bit sv, input bit br);
        vec_t v;
        v.data = data; v.gap = gap; v.fl = fl; v.held = held;
        v.pa = pa; v.pb = pb; v.ra = ra; v.rb = rb;
        v.sc = sc; v.sv = sv; v.br = br;
        return v;
    endfunction

    task automatic checkOutput(input vec_t v, input string name);
        logic [41:0] got;
        logic [41:0] exp;
        got = {up_a, right_a, down_a, left_a, up_b, right_b, down_b, left_b,
               press_a, press_b, release_a, release_b, sc_a, sv_a, br_a};
        exp = {v.held, v.held, v.pa, v.pb, v.ra, v.rb, v.sc, v.sv, v.br};
        vectors++;
        if (got !== exp || sc_b !== v.sc || sv_b !== v.sv || br_b !== v.br) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h (b sc=%h sv=%b br=%b) expected %h",
                     name, got, sc_b, sv_b, br_b, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        repeat (v.gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = v.data;
        rx_valid = 1'b1;
        flush    = v.fl;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        vec_t z;
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        z = mk(8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0);
        checkOutput(z, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //            data   gap fl held  pa    pb    ra    rb    sc        sv br
        tbl.push_back(mk(8'hE0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h75, 0, 0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 16'hE075, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE075, 0, 0));
        tbl.push_back(mk(8'h75, 0, 0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 16'hE075, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE075, 0, 0));
        tbl.push_back(mk(8'h6B, 0, 0, 4'h9, 4'h1, 4'h1, 4'h0, 4'h0, 16'hE06B, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE06B, 0, 0));
        tbl.push_back(mk(8'h74, 1, 0, 4'hD, 4'h4, 4'h4, 4'h0, 4'h0, 16'hE074, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE074, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE074, 0, 0));
        tbl.push_back(mk(8'h74, 0, 0, 4'h9, 4'h0, 4'h0, 4'h4, 4'h4, 16'hE074, 1, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE074, 0, 1));
        tbl.push_back(mk(8'hF0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE074, 0, 1));
        tbl.push_back(mk(8'h74, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h4, 16'hE074, 1, 1));
        tbl.push_back(mk(8'h6B, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h006B, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h006B, 0, 0));
        tbl.push_back(mk(8'h1C, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h001C, 1, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h001C, 0, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h001C, 0, 1));
        tbl.push_back(mk(8'h72, 0, 0, 4'hB, 4'h2, 4'h2, 4'h0, 4'h0, 16'hE072, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE072, 0, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'h00E0, 1, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'h00E0, 0, 1));
        tbl.push_back(mk(8'hF0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'h00E0, 0, 1));
        tbl.push_back(mk(8'h72, 0, 0, 4'h9, 4'h0, 4'h0, 4'h2, 4'h2, 16'hE072, 1, 1));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE072, 0, 1));
        tbl.push_back(mk(8'h72, 8, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0072, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0072, 0, 0));
        tbl.push_back(mk(8'h72, 7, 0, 4'hB, 4'h2, 4'h2, 4'h0, 4'h0, 16'hE072, 1, 0));
        tbl.push_back(mk(8'hF0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'hE072, 0, 0));
        tbl.push_back(mk(8'h1C, 8, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'h001C, 1, 0));
        tbl.push_back(mk(8'hE0, 0, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 16'h001C, 0, 0));
        tbl.push_back(mk(8'h75, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h75, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0075, 1, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset pulsed between E0 and F0 while up is held.
        applyStimulus(mk(8'hE0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        applyStimulus(mk(8'h75, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        checkOutput(mk(8'h75, 0, 0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 16'hE075, 1, 0), "up_before_rst");
        applyStimulus(mk(8'hE0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        #2;
        rst_n = 1'b0;
        #2;
        checkOutput(z, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(mk(8'h75, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0));
        checkOutput(mk(8'h75, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0075, 1, 0), "after_rst");
        @(posedge clk);
        #1;
        checkOutput(mk(8'h00, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0075, 0, 0), "pulse_drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_arrow_tracker.md
Name: ps2_arrow_tracker

Overview:
- Sequential successor to the combinational arrow-key scancode decoder.
- Consumes the raw PS/2 byte stream, one byte per `rx_valid` pulse, from the PS/2 receiver.
- Parses the E0 (extended) and F0 (break) prefixes.
- Maintains held state for the four arrow keys, and emits press/release pulses plus the last complete scancode.
- Feeds game/cursor logic that needs key-hold levels rather than per-code decodes.

Parameters:
- TIMEOUT_CYCLES, 16'd50000, clk cycles without `rx_valid` after which a partial prefix sequence is discarded; 0 disables the timeout.
- REPEAT_FILTER, 1, 1: typematic repeats of an already-held key produce no `key_press` pulse, and breaks of a non-held key produce no `key_release` pulse; 0: every make/break pulses.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of parser state and held keys
- rx_data  input  8  received PS/2 byte
- rx_valid  input  1  one-cycle strobe; `rx_data` valid this cycle
- left  output  1  left arrow (E0 6B) held
- down  output  1  down arrow (E0 72) held
- right  output  1  right arrow (E0 74) held
- up  output  1  up arrow (E0 75) held
- key_press  output  4  one-cycle make pulse; bit order [0]=left, [1]=down, [2]=right, [3]=up
- key_release  output  4  one-cycle break pulse; same bit order
- scancode  output  16  last complete code: {E0,xx} if extended, else {00,xx}
- scancode_valid  output  1  one-cycle pulse when `scancode` updates
- is_break  output  1  `scancode` was a break code; valid with `scancode_valid`, held until the next update

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `left`, `down`, `right`, `up` = 0.
  - `key_press`, `key_release` = 0.
  - `scancode` = 16'h0000, `scancode_valid` = 0, `is_break` = 0.
  - FSM = IDLE, timeout counter = 0.
- `flush` (synchronous, highest priority after reset): same values as reset on the next edge. A `rx_valid` in the same cycle is dropped.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on `rx_valid`:
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> complete make {00,byte}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT (duplicate prefix absorbed); other -> complete make {E0,byte}, go to IDLE.
  - BRK: any byte (including E0/F0) -> complete break {00,byte}, go to IDLE.
  - EXT_BRK: any byte -> complete break {E0,byte}, go to IDLE.
- Completion latency: all outputs update on the clk edge that samples the final `rx_valid` (registered, 1-cycle latency). `scancode_valid`, `key_press`, `key_release` are high for exactly that one cycle.
- Arrow handling on completion, with k = arrow index:
  - Make of arrow k: held[k] <= 1. `key_press[k]` pulses if REPEAT_FILTER=0, or if held[k] was 0.
  - Break of arrow k: held[k] <= 0. `key_release[k]` pulses if REPEAT_FILTER=0, or if held[k] was 1.
- Non-arrow codes, including non-extended 6B/72/74/75 (keypad): update `scancode`/`is_break` only; held state is unchanged.
- Multiple keys may be held simultaneously. At most one bit of `key_press` or `key_release` is set in any cycle.
- Timeout:
  - Counter clears on every `rx_valid` and whenever the FSM is in IDLE.
  - In EXT/BRK/EXT_BRK it increments each cycle, saturating.
  - On reaching TIMEOUT_CYCLES the FSM returns to IDLE and the prefix is discarded, with no `scancode_valid`.
  - A `rx_valid` in that same cycle wins: the byte is processed in the current state.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. TIMEOUT_CYCLES=0 means the counter never fires.
- Reset asserted mid-sequence: prefix is lost and held keys are cleared. After release the FSM starts in IDLE.
- No latches: every output and state register has a defined next value on every path.

Test Plan:
- Reset, then bytes E0,75 -> one cycle after the second strobe: `up`=1, `key_press`=4'b1000, `scancode`=16'hE075, `scancode_valid`=1, `is_break`=0.
- With up held, bytes E0,75 again (REPEAT_FILTER=1) -> `up` stays 1, `key_press`=0, `scancode_valid`=1. Repeat with REPEAT_FILTER=0 -> `key_press`=4'b1000.
- Hold left and right (E0,6B then E0,74), then break right (E0,F0,74) -> `left`=1, `right`=0, `key_release`=4'b0100, `scancode`=16'hE074, `is_break`=1.
- Non-extended 6B then F0,1C -> held outputs unchanged. `scancode` sequence is 16'h006B (make), then 16'h001C with `is_break`=1.
- TIMEOUT_CYCLES=8: send E0, idle 8 cycles, then send 72 -> `scancode`=16'h0072, `down` stays 0. With a gap of 7 cycles -> `down`=1.
- Hold up, then assert `flush` (or pulse `rst_n` low between E0 and F0) -> all held outputs 0 and FSM in IDLE. Next byte 75 alone yields `scancode`=16'h0075, not a break.
